text_overlay: RTL and testbench

- Character-cell text buffer and raster consumer for the 5x7 ASCII font engine.
- A host writes a byte stream (printable characters plus control codes) through a valid/ready port into a COLS x ROWS character RAM.
- During scan-out, the block looks up the character code at the font engine's current char_x/char_y and selects that code's bit from ascii_char to produce a 1-bit pixel.
- Sits between the font engine and the video output mux.

---
 rtl/text_overlay_if.sv | 9 +
 rtl/text_overlay.sv | 167 ++++++++++++++++
 tb/tb_text_overlay.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/text_overlay_if.sv
// Host byte-stream handshake for the text overlay character buffer.
interface text_overlay_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_overlay.sv
// Character-cell text buffer with host byte port and 2-stage raster pixel lookup.
// Optional cursor blink enabled by defining TEXT_OVERLAY_CURSOR_BLINK_EN.
//
// state   | meaning
// CLEAR   | fill every cell with 0x20, one per cycle; host port stalled
// IDLE    | accept host bytes, update cursor / cell contents
module text_overlay #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                blank,
  input  logic                vsync,
  input  logic [7:0]          char_x,
  input  logic [7:0]          char_y,
  input  logic [255:0]        ascii_char,
  text_overlay_if.slave       host,
  output logic [7:0]          cursor_col,
  output logic [7:0]          cursor_row,
  output logic                pix
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [7:0]    LAST_COL  = 8'(COLS - 1);
  localparam logic [7:0]    LAST_ROW  = 8'(ROWS - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_addr;
  logic          clr_we;
  logic          rdy;
  logic          accept;
  logic          is_print;
  logic          mem_we;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_byte;
  logic          in_win;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_code;
  logic          in_win_d;
  logic          blank_d;
  logic          invert;
  logic [7:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_addr == LAST_ADDR) state_nxt = S_IDLE;
      S_IDLE:  if (accept && host.wr_data == 8'h0C) state_nxt = S_CLEAR;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Ready is masked by reset so a byte offered during reset is never taken.
  always_comb begin
    rdy    = 1'b0;
    clr_we = 1'b0;
    case (state)
      S_CLEAR: clr_we = 1'b1;
      S_IDLE:  rdy    = !reset;
      default: ;
    endcase
  end

  assign host.wr_ready = rdy;
  assign accept        = host.wr_valid && rdy;
  assign is_print      = (host.wr_data >= 8'h20) && (host.wr_data <= 8'h7E);

  assign cur_addr = AW'(int'(cursor_row) * COLS + int'(cursor_col));
  assign mem_we   = clr_we || (accept && is_print);
  assign wr_addr  = clr_we ? clr_addr : cur_addr;
  assign wr_byte  = clr_we ? 8'h20 : host.wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr   <= '0;
      cursor_col <= 8'd0;
      cursor_row <= 8'd0;
    end else if (clr_we) begin
      clr_addr   <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + AW'(1);
      cursor_col <= 8'd0;
      cursor_row <= 8'd0;
    end else if (accept) begin
      if (is_print) begin
        if (cursor_col == LAST_COL) begin
          cursor_col <= 8'd0;
          cursor_row <= (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
        end else begin
          cursor_col <= cursor_col + 8'd1;
        end
      end else begin
        case (host.wr_data)
          8'h0D: cursor_col <= 8'd0;
          8'h0A: begin
            cursor_col <= 8'd0;
            cursor_row <= (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
          end
          8'h08: if (cursor_col != 8'd0) cursor_col <= cursor_col - 8'd1;
          8'h0C: begin
            clr_addr   <= '0;
            cursor_col <= 8'd0;
            cursor_row <= 8'd0;
          end
          default: ;
        endcase
      end
    end
  end

  // Out-of-window coordinates read cell 0; the result is masked by in_win anyway.
  assign in_win  = (int'(char_x) < COLS) && (int'(char_y) < ROWS);
  assign rd_addr = in_win ? AW'(int'(char_y) * COLS + int'(char_x)) : '0;

  // Read-before-write: a same-cell read in the write cycle returns the old byte.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_byte;
    rd_code <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_win_d <= 1'b0;
      blank_d  <= 1'b1;
      pix      <= 1'b0;
    end else begin
      in_win_d <= in_win;
      blank_d  <= blank;
      pix      <= (ascii_char[rd_code] ^ invert) && in_win_d && !blank_d;
    end
  end

`ifdef TEXT_OVERLAY_CURSOR_BLINK_EN
  logic       vsync_d;
  logic [4:0] frame_cnt;
  logic       at_cursor_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      frame_cnt   <= 5'd0;
      at_cursor_d <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      at_cursor_d <= (char_x == cursor_col) && (char_y == cursor_row);
      if (vsync && !vsync_d) frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign invert = frame_cnt[4] && at_cursor_d;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign invert       = 1'b0;
`endif

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: vector table, queued raster expectations,
// and hand sequences for clear timing, cursor wrap and mid-clear reset.
module tb_text_overlay;

  logic         clk = 1'b0;
  logic         reset;
  logic         blank;
  logic         vsync;
  logic [7:0]   char_x;
  logic [7:0]   char_y;
  logic [255:0] ascii_char;
  logic [7:0]   cursor_col;
  logic [7:0]   cursor_row;
  logic         pix;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  text_overlay_if bus ();

  text_overlay #(.COLS(80), .ROWS(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .blank      (blank),
    .vsync      (vsync),
    .char_x     (char_x),
    .char_y     (char_y),
    .ascii_char (ascii_char),
    .host       (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .pix        (pix)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         do_wr;
    logic [7:0]   wr_byte;
    logic [7:0]   x;
    logic [7:0]   y;
    logic         blk;
    logic [255:0] font;
    logic         exp_pix;
    logic [7:0]   exp_col;
    logic [7:0]   exp_row;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [255:0] oh(input int c);
    logic [255:0] f;
    f    = '0;
    f[c] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    while (!bus.wr_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("write_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic raster(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic blk, input logic [255:0] font, input logic exp);
    @(negedge clk);
    char_x = x;
    char_y = y;
    blank  = blk;
    exp_q.push_back(exp);
    @(negedge clk);
    ascii_char = font;
    @(negedge clk);
    check(name, 32'(pix), 32'(exp_q.pop_front()));
    blank = 1'b0;
  endtask

  task automatic measure_busy(output int cnt, output logic cur_ok);
    cnt    = 0;
    cur_ok = 1'b1;
    while (!bus.wr_ready && cnt < 3000) begin
      if (cursor_col != 8'd0 || cursor_row != 8'd0) cur_ok = 1'b0;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_cursor(input string name, input logic [7:0] c, input logic [7:0] r);
    check({name, "_col"}, 32'(cursor_col), 32'(c));
    check({name, "_row"}, 32'(cursor_row), 32'(r));
  endtask

  initial begin
    int   cnt;
    logic cur_ok;

    reset        = 1'b1;
    blank        = 1'b0;
    vsync        = 1'b0;
    char_x       = 8'd0;
    char_y       = 8'd0;
    ascii_char   = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;

    //              wr    byte   x      y      blk   font           pix  col    row
    vecs[0]  = '{1'b0, 8'h00, 8'd0,  8'd0,  1'b0, ~oh(8'h20),    1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 8'd79, 8'd29, 1'b0, '1,            1'b1, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 8'h00, 8'd80, 8'd0,  1'b0, '1,            1'b0, 8'd0, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 8'd0,  8'd30, 1'b0, '1,            1'b0, 8'd0, 8'd0};
    vecs[4]  = '{1'b0, 8'h00, 8'd5,  8'd5,  1'b1, '1,            1'b0, 8'd0, 8'd0};
    vecs[5]  = '{1'b1, 8'h41, 8'd0,  8'd0,  1'b0, oh(8'h41),     1'b1, 8'd1, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 8'd0,  8'd0,  1'b0, ~oh(8'h41),    1'b0, 8'd1, 8'd0};
    vecs[7]  = '{1'b1, 8'h08, 8'd1,  8'd0,  1'b0, oh(8'h20),     1'b1, 8'd0, 8'd0};
    vecs[8]  = '{1'b1, 8'h08, 8'd0,  8'd0,  1'b0, oh(8'h41),     1'b1, 8'd0, 8'd0};
    vecs[9]  = '{1'b1, 8'h43, 8'd0,  8'd0,  1'b0, oh(8'h43),     1'b1, 8'd1, 8'd0};
    vecs[10] = '{1'b1, 8'h0D, 8'd1,  8'd0,  1'b0, oh(8'h20),     1'b1, 8'd0, 8'd0};
    vecs[11] = '{1'b1, 8'h0A, 8'd0,  8'd1,  1'b0, ~oh(8'h20),    1'b0, 8'd0, 8'd1};
    vecs[12] = '{1'b1, 8'h07, 8'd0,  8'd1,  1'b0, oh(8'h20),     1'b1, 8'd0, 8'd1};
    vecs[13] = '{1'b1, 8'h7E, 8'd0,  8'd1,  1'b0, oh(8'h7E),     1'b1, 8'd1, 8'd1};
    vecs[14] = '{1'b1, 8'h7F, 8'd1,  8'd1,  1'b0, oh(8'h20),     1'b1, 8'd1, 8'd1};

    // Reset state and initial clear length
    @(negedge clk);
    check("rst_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check_cursor("rst_cursor", 8'd0, 8'd0);
    reset = 1'b0;
    measure_busy(cnt, cur_ok);
    check("init_clear_cycles", 32'(cnt), 32'd2400);
    check("init_clear_cursor", 32'(cur_ok), 32'd1);
    check_cursor("post_clear", 8'd0, 8'd0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_wr) write_byte(vecs[i].wr_byte);
      check_cursor($sformatf("vec%0d_cursor", i), vecs[i].exp_col, vecs[i].exp_row);
      raster($sformatf("vec%0d_pix", i), vecs[i].x, vecs[i].y, vecs[i].blk,
             vecs[i].font, vecs[i].exp_pix);
    end

    // Column wrap at end of row, row wrap on LF and on printable at last cell
    write_byte(8'h0A);
    for (int i = 0; i < 80; i++) write_byte(8'h42);
    check_cursor("col_wrap", 8'd0, 8'd3);
    raster("col_wrap_pix", 8'd79, 8'd2, 1'b0, oh(8'h42), 1'b1);
    for (int i = 0; i < 26; i++) write_byte(8'h0A);
    check_cursor("row29", 8'd0, 8'd29);
    write_byte(8'h0A);
    check_cursor("lf_wrap", 8'd0, 8'd0);
    for (int i = 0; i < 29; i++) write_byte(8'h0A);
    for (int i = 0; i < 80; i++) write_byte(8'h44);
    check_cursor("print_wrap", 8'd0, 8'd0);
    raster("last_cell_pix", 8'd79, 8'd29, 1'b0, oh(8'h44), 1'b1);
    write_byte(8'h45);
    check_cursor("pre_ff", 8'd1, 8'd0);

    // Form feed with wr_valid held high
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h0C;
    check("ff_ready_before", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    bus.wr_data = 8'h41;
    measure_busy(cnt, cur_ok);
    check("ff_clear_cycles", 32'(cnt), 32'd2400);
    check("ff_no_accept", 32'(cur_ok), 32'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check_cursor("ff_after", 8'd1, 8'd0);
    raster("ff_new_cell", 8'd0, 8'd0, 1'b0, oh(8'h41), 1'b1);
    raster("ff_cleared_old", 8'd79, 8'd29, 1'b0, oh(8'h44), 1'b0);
    raster("ff_cleared_blank", 8'd79, 8'd29, 1'b0, oh(8'h20), 1'b1);

    // Reset in the middle of a clear restarts from address 0
    write_byte(8'h0C);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure_busy(cnt, cur_ok);
    check("midrst_clear_cycles", 32'(cnt), 32'd2400);
    check_cursor("midrst_cursor", 8'd0, 8'd0);
    raster("midrst_cell", 8'd0, 8'd0, 1'b0, oh(8'h41), 1'b0);

`ifdef TEXT_OVERLAY_CURSOR_BLINK_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
    raster("blink_on", 8'd0, 8'd0, 1'b0, '0, 1'b1);
    raster("blink_on_blank", 8'd0, 8'd0, 1'b1, '0, 1'b0);
    raster("blink_other_cell", 8'd3, 8'd0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
    raster("blink_off", 8'd0, 8'd0, 1'b0, '0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
